temp_sense_ctrl: RTL and testbench

TEMP_SENSE_CTRL -- requirements
Module: temp_sense_ctrl

---
 rtl/temp_sense_ctrl_pkg.sv | 17 +
 rtl/temp_sense_ctrl_if.sv | 12 +
 rtl/temp_sense_ctrl_sensor_spi_rx.sv | 56 +++++
 rtl/temp_sense_ctrl.sv | 59 +++++
 tb/tb_temp_sense_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/temp_sense_ctrl_pkg.sv
// temp_sense_ctrl_pkg: shared FSM state, default parameters and helpers for the temperature controller
package temp_sense_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  localparam int DEF_CLK_DIV       = 4;
  localparam int DEF_SAMPLE_PERIOD = 1000;
  localparam int DEF_SPEED_GAIN    = 16;
  localparam int DEF_RAMP_DIV      = 64;
  localparam int FILT_DEPTH        = 4;
  // fan target: |temp - setpoint| scaled by gain, saturated to 8 bits
  function automatic logic [7:0] sat_target(input logic [7:0] temp, input logic [7:0] setpoint, input int gain);
    logic [7:0] err;
    int p;
    err = temp > setpoint ? temp - setpoint : setpoint - temp;
    p = int'(err) * gain;
    return p > 255 ? 8'hff : p[7:0];
  endfunction
endpackage

// File: rtl/temp_sense_ctrl_if.sv
// temp_sense_ctrl_if: sensor serial bus plus cool/heat system signals
interface temp_sense_ctrl_if;
  logic [7:0] setpoint;
  logic       sen_sdo;
  logic       sen_cs_n;
  logic       sen_sclk;
  logic [7:0] chs_conf;
  logic       conf_valid;
  logic [7:0] speed;
  modport master (output setpoint, sen_sdo, input sen_cs_n, sen_sclk, chs_conf, conf_valid, speed);
  modport slave (input setpoint, sen_sdo, output sen_cs_n, sen_sclk, chs_conf, conf_valid, speed);
endinterface

// File: rtl/temp_sense_ctrl_sensor_spi_rx.sv
// sensor_spi_rx: periodic conversion sequencer reading one MSB-first byte from the sensor
module sensor_spi_rx
  import temp_sense_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       sdo,
  output logic       cs_n,
  output logic       sclk,
  output logic [7:0] data,
  output logic       done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  state_t state, state_nx;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] div_cnt;
  logic [2:0] bit_cnt;
  logic tick, per_end, rise, fall;
  assign tick    = div_cnt == DW'(CLK_DIV - 1);
  assign per_end = per_cnt == PW'(SAMPLE_PERIOD - 1);
  assign rise    = state == SHIFT && tick && !sclk;
  assign fall    = state == SHIFT && tick && sclk;
  // state register
  always_ff @(posedge clk)
    state <= arst ? state_nx : IDLE;
  // next state: wait period, chip-select setup, 8 sclk periods, one-cycle done
  always_comb
    state_nx = (state == IDLE && per_end) ? SETUP :
               (state == SETUP && tick) ? SHIFT :
               (fall && bit_cnt == 3'd7) ? DONE :
               state == DONE ? IDLE : state;
  // outputs decoded from state
  always_comb begin
    cs_n = !(state == SETUP || state == SHIFT);
    done = state == DONE;
  end
  // period/half-period/bit counters, sclk generation and MSB-first shift on sclk rise
  always_ff @(posedge clk)
    if (!arst) begin
      per_cnt <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      data    <= '0;
    end else begin
      per_cnt <= (state == IDLE && !per_end) ? per_cnt + 1'b1 : '0;
      div_cnt <= ((state == SETUP || state == SHIFT) && !tick) ? div_cnt + 1'b1 : '0;
      if (rise) data <= {data[6:0], sdo};
      if (fall) bit_cnt <= bit_cnt + 1'b1;
      if (state == SHIFT && tick) sclk <= !sclk;
    end
endmodule

// File: rtl/temp_sense_ctrl.sv
// temp_sense_ctrl: sensor readout, 4-entry moving average and ramped fan speed control
module temp_sense_ctrl
  import temp_sense_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int SPEED_GAIN    = DEF_SPEED_GAIN,
  parameter int RAMP_DIV      = DEF_RAMP_DIV
) (
  input logic clk,
  input logic arst,
  temp_sense_ctrl_if.slave bus
);
  localparam int RW = $clog2(RAMP_DIV);
  logic [7:0] rx_data, win [FILT_DEPTH], speed, target;
  logic rx_done, cs_n, sclk, primed, conf_valid, step;
  logic [9:0] acc, acc_nx;
  logic [RW-1:0] rcnt;
  sensor_spi_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) u_rx (
    .clk(clk), .arst(arst), .sdo(bus.sen_sdo), .cs_n(cs_n), .sclk(sclk), .data(rx_data), .done(rx_done)
  );
  assign bus.sen_cs_n   = cs_n;
  assign bus.sen_sclk   = sclk;
  assign bus.chs_conf   = acc[9:2];
  assign bus.conf_valid = conf_valid;
  assign bus.speed      = speed;
  assign step = rcnt == RW'(RAMP_DIV - 1);
  // running window sum; the first sample after reset fills every entry
  always_comb
    acc_nx = primed ? acc - 10'(win[FILT_DEPTH-1]) + 10'(rx_data) : {rx_data, 2'b00};
  // no measurement yet means no demand, so the fan stays off until the filter primes
  always_comb
    target = primed ? sat_target(acc[9:2], bus.setpoint, SPEED_GAIN) : 8'd0;
  // filter window update on each completed conversion
  always_ff @(posedge clk)
    if (!arst) begin
      win        <= '{default: '0};
      primed     <= 1'b0;
      acc        <= '0;
      conf_valid <= 1'b0;
    end else begin
      conf_valid <= rx_done;
      if (rx_done) begin
        win[0] <= rx_data;
        for (int i = 1; i < FILT_DEPTH; i++) win[i] <= primed ? win[i-1] : rx_data;
        primed <= 1'b1;
        acc    <= acc_nx;
      end
    end
  // free-running ramp divider; speed moves one step toward the current target
  always_ff @(posedge clk)
    if (!arst) begin
      rcnt  <= '0;
      speed <= '0;
    end else begin
      rcnt <= step ? '0 : rcnt + 1'b1;
      if (step) speed <= speed < target ? speed + 1'b1 : speed > target ? speed - 1'b1 : speed;
    end
endmodule

// File: tb/tb_temp_sense_ctrl.sv
// tb_temp_sense_ctrl: directed bench with sensor model and conversion scoreboard
module tb_temp_sense_ctrl;
  logic clk = 1'b0;
  logic arst;
  int vectors = 0;
  int miscompares = 0;
  int conf_seen = 0;
  int bidx = 0;
  int rises = 0;
  logic [7:0] sb;
  logic [7:0] mw [4];
  bit mprimed = 1'b0;
  int q [$];

  temp_sense_ctrl_if bus ();
  temp_sense_ctrl dut (.clk(clk), .arst(arst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.sen_sdo = (bidx < 8) ? sb[3'(7 - bidx)] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // sensor model: new byte per chip-select window, shifted out on sclk falling edges
  always @(negedge bus.sen_cs_n) begin
    int s;
    bidx = 0;
    rises = 0;
    if (!mprimed) begin
      for (int i = 0; i < 4; i++) mw[i] = sb;
      mprimed = 1'b1;
    end else begin
      for (int i = 3; i > 0; i--) mw[i] = mw[i-1];
      mw[0] = sb;
    end
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(mw[i]);
    q.push_back(s / 4);
  end
  always @(negedge bus.sen_sclk) bidx++;
  always @(posedge bus.sen_sclk) rises++;

  // scoreboard: every conf_valid pops one expected filter output
  always @(negedge clk)
    if (arst === 1'b1 && bus.conf_valid === 1'b1) begin
      conf_seen++;
      chk("conf_expected", q.size() > 0, 1);
      if (q.size() > 0) chk("chs_conf", bus.chs_conf, q.pop_front());
      chk("sclk_rises", rises, 8);
    end

  task automatic wait_start(input string tag);
    int n;
    for (n = 1; n < 2000; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.sen_cs_n) break;
    end
    chk(tag, n, 1000);
  endtask

  task automatic wait_conf(input string tag);
    int c0 = conf_seen;
    for (int i = 0; i < 2500 && conf_seen == c0; i++) @(negedge clk);
    chk(tag, conf_seen != c0, 1);
  endtask

  task automatic wait_speed(input string tag, input int v, input int bound);
    for (int i = 0; i < bound && bus.speed != 8'(v); i++) @(negedge clk);
    chk(tag, bus.speed, v);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cs_n"}, bus.sen_cs_n, 1);
    chk({tag, "_sclk"}, bus.sen_sclk, 0);
    chk({tag, "_chs"}, bus.chs_conf, 0);
    chk({tag, "_valid"}, bus.conf_valid, 0);
    chk({tag, "_speed"}, bus.speed, 0);
  endtask

  initial begin
    int seq [5] = '{0, 16, 32, 48, 64};
    int s0;
    arst = 1'b0;
    bus.setpoint = 8'd40;
    sb = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    arst = 1'b1;
    wait_start("first_start");
    for (int i = 0; i < 5; i++) begin
      wait_conf("conf_timeout");
      chk("chs_seq", bus.chs_conf, seq[i]);
      sb = 8'h40;
    end
    s0 = int'(bus.speed);
    repeat (64) @(negedge clk);
    chk("ramp_up_step1", bus.speed, s0 + 1);
    repeat (64) @(negedge clk);
    chk("ramp_up_step2", bus.speed, s0 + 2);
    wait_speed("ramp_up_reach", 255, 256 * 64 + 200);
    repeat (300) @(negedge clk);
    chk("ramp_hold_255", bus.speed, 255);
    bus.setpoint = 8'd64;
    wait_speed("ramp_down_100", 100, 160 * 64 + 200);
    repeat (64) @(negedge clk);
    chk("ramp_down_99", bus.speed, 99);
    repeat (64) @(negedge clk);
    chk("ramp_down_98", bus.speed, 98);
    wait_speed("ramp_down_0", 0, 100 * 64 + 200);
    repeat (300) @(negedge clk);
    chk("ramp_hold_0", bus.speed, 0);
    bus.setpoint = 8'd0;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 3000 && !(bus.sen_cs_n == 1'b0 && rises == 4); i++) @(negedge clk);
    chk("mid_shift_rises", rises, 4);
    chk("mid_shift_speed_nz", bus.speed != 0, 1);
    arst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    q.delete();
    mprimed = 1'b0;
    sb = 8'h40;
    arst = 1'b1;
    wait_start("restart_start");
    wait_conf("refill_timeout");
    chk("refill_chs", bus.chs_conf, 64);
    arst = 1'b0;
    bus.setpoint = 8'd255;
    sb = 8'hff;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    mprimed = 1'b0;
    arst = 1'b1;
    wait_conf("ff_timeout1");
    chk("ff_chs1", bus.chs_conf, 255);
    chk("ff_speed1", bus.speed, 0);
    repeat (500) @(negedge clk);
    chk("ff_speed_mid", bus.speed, 0);
    wait_conf("ff_timeout2");
    chk("ff_chs2", bus.chs_conf, 255);
    chk("ff_speed2", bus.speed, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
